// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if -- one requester's connection to the data-memory arbiter.
//   req/we/addr/wdata : request (driven by the requester, held until gnt)
//   gnt               : request accepted (one cycle)
//   done/err/rdata    : completion pulse, out-of-range flag, read data
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, done, err, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, done, err, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-port arbiter in front of a single-port data memory.
// One access at a time: IDLE (arbitrate/latch) -> ACCESS (strobe memory,
// grant) -> RESP (done/err/rdata) -> IDLE.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   p0, p1             : requester interfaces (slave side)
//   mem_r_addr/read    : memory read address/strobe
//   mem_w_addr/write   : memory write address/strobe
//   mem_data_in        : memory write data
//   mem_data_out       : combinational memory read data
// Parameters: DEPTH = valid word count, FIXED_PRI = 1 makes port 0 always win.
//
// state  | meaning
// IDLE   | waiting; arbitrates and latches the winning request
// ACCESS | memory strobe (if in range), grant pulse to winner
// RESP   | done pulse, err and rdata presented to winner
module dmem_arbiter #(
  parameter int unsigned DEPTH     = 32,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  p0,
  dmem_arbiter_if.slave  p1,
  output logic [31:0]    mem_r_addr,
  output logic [31:0]    mem_w_addr,
  output logic [31:0]    mem_data_in,
  output logic           mem_read,
  output logic           mem_write,
  input  logic [31:0]    mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        id_q, we_q, last_gnt_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q;
  logic        any_req, win_id, in_range, acc, rsp;

  // Next state and arbitration
  always_comb begin
    state_d = state_q;
    any_req = p0.req | p1.req;
    if (FIXED_PRI)
      win_id = ~p0.req;
    else
      // on a tie, the port not granted last time wins
      win_id = p1.req & (~p0.req | ~last_gnt_q);
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_gnt_q <= 1'b1;   // port 0 wins the first tie
      err_q      <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            id_q       <= win_id;
            we_q       <= win_id ? p1.we    : p0.we;
            addr_q     <= win_id ? p1.addr  : p0.addr;
            wdata_q    <= win_id ? p1.wdata : p0.wdata;
            last_gnt_q <= win_id;
          end
        end
        ACCESS: begin
          err_q <= ~in_range;
          if (id_q)
            rdata1_q <= (~we_q & in_range) ? mem_data_out : 32'h0;
          else
            rdata0_q <= (~we_q & in_range) ? mem_data_out : 32'h0;
        end
        default: ;
      endcase
    end
  end

  // Outputs. Gating with rst_n keeps a write from landing on the edge
  // where reset aborts an access, and holds every flag low during reset.
  always_comb begin
    in_range    = (addr_q < DEPTH);
    acc         = (state_q == ACCESS) & rst_n;
    rsp         = (state_q == RESP) & rst_n;
    mem_read    = acc & ~we_q & in_range;
    mem_write   = acc & we_q & in_range;
    mem_r_addr  = mem_read  ? addr_q  : 32'h0;
    mem_w_addr  = mem_write ? addr_q  : 32'h0;
    mem_data_in = mem_write ? wdata_q : 32'h0;
  end

  assign p0.gnt   = acc & ~id_q;
  assign p1.gnt   = acc & id_q;
  assign p0.done  = rsp & ~id_q;
  assign p1.done  = rsp & id_q;
  assign p0.err   = rsp & ~id_q & err_q;
  assign p1.err   = rsp & id_q & err_q;
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- directed bench for dmem_arbiter. Two instances share the
// same requester stimulus: dut_rr (round-robin, with a word-addressed memory
// model preset to mem[i] = i) and dut_fp (fixed priority).
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic fill;
  always #5 clk = ~clk;

  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;

  dmem_arbiter_if a0 ();
  dmem_arbiter_if a1 ();
  dmem_arbiter_if b0 ();
  dmem_arbiter_if b1 ();

  assign a0.req = r0_req;  assign a0.we = r0_we;  assign a0.addr = r0_addr;  assign a0.wdata = r0_wdata;
  assign a1.req = r1_req;  assign a1.we = r1_we;  assign a1.addr = r1_addr;  assign a1.wdata = r1_wdata;
  assign b0.req = r0_req;  assign b0.we = r0_we;  assign b0.addr = r0_addr;  assign b0.wdata = r0_wdata;
  assign b1.req = r1_req;  assign b1.we = r1_we;  assign b1.addr = r1_addr;  assign b1.wdata = r1_wdata;

  logic [31:0] mem_r_addr, mem_w_addr, mem_data_in, mem_data_out;
  logic        mem_read, mem_write;
  logic [31:0] fp_r_addr, fp_w_addr, fp_data_in, fp_data_out;
  logic        fp_read, fp_write;
  logic [31:0] mem [32];

  dmem_arbiter #(.DEPTH(32), .FIXED_PRI(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .p0(a0.slave), .p1(a1.slave),
    .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_out(mem_data_out));

  dmem_arbiter #(.DEPTH(32), .FIXED_PRI(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .p0(b0.slave), .p1(b1.slave),
    .mem_r_addr(fp_r_addr), .mem_w_addr(fp_w_addr), .mem_data_in(fp_data_in),
    .mem_read(fp_read), .mem_write(fp_write), .mem_data_out(fp_data_out));

  assign mem_data_out = mem[mem_r_addr[4:0]];
  assign fp_data_out  = fp_r_addr + 32'h100;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 32; i++) mem[i] <= i;
    end else if (mem_write) begin
      mem[mem_w_addr[4:0]] <= mem_data_in;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_rr;
    logic [1:0] exp_fp;
    rst_n = 1'b0; fill = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    repeat (2) @(negedge clk);
    fill = 1'b0;

    // reset state
    check_val("rst_flags", {a0.gnt, a0.done, a0.err, a1.gnt, a1.done, a1.err, mem_read, mem_write}, 32'h0);
    check_val("rst_rdata", a0.rdata | a1.rdata, 32'h0);
    check_val("rst_mbus", mem_r_addr | mem_w_addr | mem_data_in, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_gnt", {a1.gnt, a0.gnt}, 32'h0);

    // read port 0, addr 2
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd2;
    @(negedge clk);
    check_val("rd0_gnt", {a1.gnt, a0.gnt}, 32'h1);
    check_val("rd0_strobe", {mem_read, mem_write}, 32'h2);
    check_val("rd0_raddr", mem_r_addr, 32'd2);
    r0_req = 1'b0;
    @(negedge clk);
    check_val("rd0_done", {a1.done, a0.done, a0.err}, 32'h2);
    check_val("rd0_rdata", a0.rdata, 32'd2);
    check_val("rd0_resp_strobe", {mem_read, mem_write}, 32'h0);
    @(negedge clk);
    check_val("rd0_done_low", {a0.done, a0.gnt}, 32'h0);
    check_val("rd0_rdata_hold", a0.rdata, 32'd2);

    // write port 1, addr 5
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'd5; r1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check_val("wr1_gnt", {a1.gnt, a0.gnt}, 32'h2);
    check_val("wr1_strobe", {mem_read, mem_write}, 32'h1);
    check_val("wr1_waddr", mem_w_addr, 32'd5);
    check_val("wr1_wdata", mem_data_in, 32'hDEADBEEF);
    check_val("wr1_raddr0", mem_r_addr, 32'h0);
    r1_req = 1'b0;
    @(negedge clk);
    check_val("wr1_done", {a1.done, a0.done, a1.err}, 32'h4);
    check_val("wr1_rdata", a1.rdata, 32'h0);
    @(negedge clk);

    // read back port 1, addr 5
    r1_req = 1'b1; r1_we = 1'b0;
    @(negedge clk);
    check_val("rb1_gnt", {a1.gnt, a0.gnt}, 32'h2);
    r1_req = 1'b0;
    @(negedge clk);
    check_val("rb1_done", a1.done, 32'h1);
    check_val("rb1_rdata", a1.rdata, 32'hDEADBEEF);
    @(negedge clk);

    // out-of-range, port 0, addr 40
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd40;
    @(negedge clk);
    check_val("oor_gnt", a0.gnt, 32'h1);
    check_val("oor_strobe", {mem_read, mem_write}, 32'h0);
    check_val("oor_raddr", mem_r_addr, 32'h0);
    r0_req = 1'b0;
    @(negedge clk);
    check_val("oor_done_err", {a0.done, a0.err}, 32'h3);
    check_val("oor_rdata", a0.rdata, 32'h0);
    @(negedge clk);
    check_val("oor_err_low", a0.err, 32'h0);

    // contention from reset, both ports reading continuously
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd1;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'd3;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_rr = (i % 3 != 0) ? 2'b00 : (((i / 3) % 2) != 0 ? 2'b10 : 2'b01);
      exp_fp = (i % 3 != 0) ? 2'b00 : 2'b01;
      check_val($sformatf("rr_gnt_%0d", i), {a1.gnt, a0.gnt}, {30'h0, exp_rr});
      check_val($sformatf("fp_gnt_%0d", i), {b1.gnt, b0.gnt}, {30'h0, exp_fp});
    end
    r0_req = 1'b0;
    @(negedge clk);
    check_val("rr_solo1", {a1.gnt, a0.gnt}, 32'h2);
    check_val("fp_solo1", {b1.gnt, b0.gnt}, 32'h2);
    r1_req = 1'b0;
    repeat (2) @(negedge clk);

    // reset during the ACCESS cycle of a port-0 write
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd7; r0_wdata = 32'h12345678;
    @(negedge clk);
    check_val("rw_gnt", a0.gnt, 32'h1);
    rst_n = 1'b0;
    r0_req = 1'b0;
    #1;
    check_val("rw_wr_gate", {mem_read, mem_write}, 32'h0);
    @(negedge clk);
    check_val("rw_flags", {a0.gnt, a0.done, a0.err, a1.gnt, a1.done, a1.err, mem_read, mem_write}, 32'h0);
    check_val("rw_mem7", mem[7], 32'd7);
    check_val("rw_rdata", a0.rdata | a1.rdata, 32'h0);
    rst_n = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd0;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'd0;
    @(negedge clk);
    check_val("rw_tie_gnt", {a1.gnt, a0.gnt}, 32'h1);
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
